digit_loader: RTL and testbench

DIGIT_LOADER -- requirements
Module: digit_loader

---
 rtl/digit_loader_pkg.sv | 15 +
 rtl/digit_loader_if.sv | 25 ++
 rtl/digit_loader_issue_timer.sv | 26 ++
 rtl/digit_loader.sv | 142 ++++++++++++++
 tb/tb_digit_loader.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/digit_loader_pkg.sv
// Shared types and constants for the digit_loader keypad-to-display loader.
package digit_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0]  BLANK         = 4'hF;
  localparam logic [3:0]  KEY_BKSP      = 4'hF;
  localparam int unsigned PULSE_LEN_DEF = 4;
  localparam int unsigned BUSY_TMO_DEF  = 16'hFFFF;

endpackage

// File: rtl/digit_loader_if.sv
// Keypad and display signal bundle for digit_loader; master drives keys, slave is the loader.
interface digit_loader_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clr;
  logic        key_enter;
  logic [1:0]  mode_in;
  logic        disp_busy;
  logic [15:0] digits;
  logic        set;
  logic        start;
  logic [1:0]  mode;
  logic        busy;
  logic        ovf;

  modport master (
    output key_valid, key_code, key_clr, key_enter, mode_in, disp_busy,
    input  digits, set, start, mode, busy, ovf
  );

  modport slave (
    input  key_valid, key_code, key_clr, key_enter, mode_in, disp_busy,
    output digits, set, start, mode, busy, ovf
  );
endinterface

// File: rtl/digit_loader_issue_timer.sv
// dl_issue_timer: loadable down-counter shared by the strobe-length and busy-timeout counts.
module dl_issue_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/digit_loader.sv
// Keypad digit buffer that issues its contents to a display with set/start strobes.
// Optional DIGIT_LOADER_AUTO_SEND_EN: every accepted digit/backspace/clear issues one cycle later.
module digit_loader
  import digit_loader_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
  parameter int unsigned BUSY_TMO  = BUSY_TMO_DEF
) (
  input logic           clk,
  input logic           rst,
  digit_loader_if.slave bus
);

`ifdef DIGIT_LOADER_AUTO_SEND_EN
  localparam bit AUTO_SEND = 1'b1;
`else
  localparam bit AUTO_SEND = 1'b0;
`endif

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
  localparam logic [15:0] TMO_LOAD   = 16'(BUSY_TMO - 1);

  state_t      state, state_n;
  logic [15:0] digits, digits_n;
  logic [2:0]  cnt, cnt_n;
  logic [1:0]  mode, mode_n;
  logic        ovf, ovf_n;
  logic        pending, pending_n;
  logic        seen_busy, seen_busy_n;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_done;
  logic        accepted;
  logic [1:0]  slot_wr, slot_bk;

  dl_issue_timer #(.WIDTH(16)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      digits    <= '1;
      cnt       <= '0;
      mode      <= '0;
      ovf       <= 1'b0;
      pending   <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      state     <= state_n;
      digits    <= digits_n;
      cnt       <= cnt_n;
      mode      <= mode_n;
      ovf       <= ovf_n;
      pending   <= pending_n;
      seen_busy <= seen_busy_n;
    end
  end

  // Digit k lands in nibble d(3-k); backspace blanks the most recent one, d(4-cnt).
  assign slot_wr = 2'(3'd3 - cnt);
  assign slot_bk = 2'(3'd4 - cnt);

  always_comb begin
    state_n     = state;
    digits_n    = digits;
    cnt_n       = cnt;
    mode_n      = mode;
    ovf_n       = ovf;
    pending_n   = 1'b0;
    seen_busy_n = seen_busy;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    accepted    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Clear outranks enter (and a pending auto-send), which outranks digit entry.
        if (bus.key_clr) begin
          digits_n = '1;
          cnt_n    = '0;
          ovf_n    = 1'b0;
          accepted = 1'b1;
        end else if (bus.key_enter || pending) begin
          mode_n   = bus.mode_in;
          state_n  = ST_ISSUE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end else if (bus.key_valid) begin
          if (bus.key_code == KEY_BKSP) begin
            if (cnt != '0) begin
              digits_n[{slot_bk, 2'b00} +: 4] = BLANK;
              cnt_n    = cnt - 3'd1;
              accepted = 1'b1;
            end
          end else if (cnt == 3'd4) begin
            ovf_n = 1'b1;
          end else begin
            digits_n[{slot_wr, 2'b00} +: 4] = bus.key_code;
            cnt_n    = cnt + 3'd1;
            accepted = 1'b1;
          end
        end
        pending_n = AUTO_SEND && accepted;
      end

      ST_ISSUE: begin
        if (tmr_done) begin
          state_n     = ST_WAIT;
          tmr_load    = 1'b1;
          tmr_val     = TMO_LOAD;
          seen_busy_n = 1'b0;
        end
      end

      ST_WAIT: begin
        if (bus.disp_busy) begin
          seen_busy_n = 1'b1;
        end
        if ((seen_busy && !bus.disp_busy) || tmr_done) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.digits = digits;
  assign bus.mode   = mode;
  assign bus.ovf    = ovf;
  assign bus.set    = (state == ST_ISSUE);
  assign bus.start  = (state == ST_ISSUE);
  assign bus.busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_digit_loader.sv
// Scoreboard bench for digit_loader: a queue-based buffer model predicts each issue,
// and a negedge monitor checks every set/start pulse and the following wait phase.
module tb_digit_loader;

  localparam int P   = 4;
  localparam int TMO = 8;

`ifdef DIGIT_LOADER_AUTO_SEND_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic [15:0] digits;
    logic [1:0]  mode;
    logic        ovf;
    int          wait_len;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_loader_if dl ();

  digit_loader #(.PULSE_LEN(P), .BUSY_TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dl)
  );

  always #5 clk = ~clk;

  int    vectors    = 0;
  int    miscompares = 0;
  item_t sb[$];

  // Reference model: entered digits in order, sticky overflow, pending auto-send.
  int mbuf[$];
  bit movf  = 1'b0;
  bit mpend = 1'b0;
  int ov_a  = 0;
  int ov_m  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdigits();
    logic [15:0] v;
    v = '1;
    for (int k = 0; k < mbuf.size(); k++) v[(12 - 4*k) +: 4] = 4'(mbuf[k]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dl.key_valid = 1'b0;
    dl.key_code  = '0;
    dl.key_clr   = 1'b0;
    dl.key_enter = 1'b0;
    dl.disp_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mbuf.delete();
    movf  = 1'b0;
    mpend = 1'b0;
  endtask

  // Runs the ISSUE and WAIT phases: junk keys are offered while the loader is busy,
  // and the display raises busy in WAIT cycles a .. a+m-1.
  task automatic run_issue(input int a, input int m, input int w);
    for (int j = 1; j <= P + TMO + 1; j++) begin
      if (j <= P + w) begin
        dl.key_valid = ($urandom_range(0, 2) == 0);
        dl.key_code  = 4'($urandom_range(0, 15));
        dl.key_clr   = ($urandom_range(0, 5) == 0);
        dl.key_enter = ($urandom_range(0, 5) == 0);
      end else begin
        dl.key_valid = 1'b0;
        dl.key_clr   = 1'b0;
        dl.key_enter = 1'b0;
      end
      dl.disp_busy = (j > P) && ((j - P) >= a) && ((j - P) < a + m);
      tick();
    end
    clear_inputs();
  endtask

  // One IDLE cycle of stimulus; predicts the loader's reaction and runs any issue it causes.
  task automatic key(input bit v, input logic [3:0] code, input bit c, input bit e,
                     input logic [1:0] mi);
    bit    iss, acc;
    int    a, m, w;
    item_t it;
    iss = 1'b0;
    acc = 1'b0;
    dl.key_valid = v;
    dl.key_code  = code;
    dl.key_clr   = c;
    dl.key_enter = e;
    dl.mode_in   = mi;
    if (c) begin
      mbuf.delete();
      movf = 1'b0;
      acc  = 1'b1;
    end else if (e || mpend) begin
      iss = 1'b1;
    end else if (v) begin
      if (code == 4'hF) begin
        if (mbuf.size() > 0) begin
          void'(mbuf.pop_back());
          acc = 1'b1;
        end
      end else if (mbuf.size() == 4) begin
        movf = 1'b1;
      end else begin
        mbuf.push_back(int'(code));
        acc = 1'b1;
      end
    end
    mpend = AUTO && acc;
    a = 0; m = 0; w = 0;
    if (iss) begin
      if (ov_a > 0) begin
        a = ov_a;
        m = ov_m;
        ov_a = 0;
      end else begin
        a = $urandom_range(1, 10);
        m = ($urandom_range(0, 4) == 0) ? 100 : $urandom_range(1, 6);
      end
      w = (a + m < TMO) ? a + m : TMO;
      it.digits   = mdigits();
      it.mode     = mi;
      it.ovf      = movf;
      it.wait_len = w;
      sb.push_back(it);
    end
    tick();
    dl.key_valid = 1'b0;
    dl.key_clr   = 1'b0;
    dl.key_enter = 1'b0;
    if (iss) run_issue(a, m, w);
  endtask

  task automatic digit(input logic [3:0] d);
    key(1'b1, d, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic enter(input logic [1:0] mi);
    key(1'b0, 4'd0, 1'b0, 1'b1, mi);
  endtask

  // Monitor: each rising set pops one expected issue; pulse length and wait length are measured.
  initial begin
    bit    in_pulse, in_wait, have;
    int    plen, wlen;
    item_t cur;
    in_pulse = 1'b0;
    in_wait  = 1'b0;
    have     = 1'b0;
    plen     = 0;
    wlen     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pulse = 1'b0;
        in_wait  = 1'b0;
      end else if (dl.set) begin
        if (!in_pulse) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got digits %0h with no issue expected at %0t",
                     dl.digits, $time);
            have = 1'b0;
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk("issue_digits", 32'(dl.digits), 32'(cur.digits));
            chk("issue_mode", 32'(dl.mode), 32'(cur.mode));
            chk("issue_ovf", 32'(dl.ovf), 32'(cur.ovf));
          end
          in_pulse = 1'b1;
          plen     = 0;
        end
        plen++;
        chk("start_eq_set", 32'(dl.start), 32'(dl.set));
        chk("busy_in_issue", 32'(dl.busy), 32'd1);
        if (have) chk("digits_stable", 32'(dl.digits), 32'(cur.digits));
      end else begin
        if (in_pulse) begin
          chk("pulse_len", 32'(plen), 32'(P));
          chk("start_low", 32'(dl.start), 32'd0);
          in_pulse = 1'b0;
          in_wait  = have;
          wlen     = 0;
        end
        if (in_wait) begin
          if (dl.busy) begin
            wlen++;
            chk("wait_digits_stable", 32'(dl.digits), 32'(cur.digits));
            chk("wait_mode_stable", 32'(dl.mode), 32'(cur.mode));
          end else begin
            chk("wait_len", 32'(wlen), 32'(cur.wait_len));
            in_wait = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    item_t it;
    int    r;
    logic [1:0] mi;
    dl.mode_in = '0;
    do_reset();
    chk("rst_digits", 32'(dl.digits), 32'hFFFF);
    chk("rst_set", 32'(dl.set), 32'd0);
    chk("rst_start", 32'(dl.start), 32'd0);
    chk("rst_mode", 32'(dl.mode), 32'd0);
    chk("rst_busy", 32'(dl.busy), 32'd0);
    chk("rst_ovf", 32'(dl.ovf), 32'd0);

    // Four digits then enter; display busy for three cycles.
    digit(4'd3); digit(4'd2); digit(4'd1); digit(4'd0);
    ov_a = 2; ov_m = 3;
    enter(2'd0);

    // Partial fill, then continued fill after an issue.
    do_reset();
    digit(4'd3); enter(2'd1);
    digit(4'd2); enter(2'd2);

    // Overflow, backspace, clear.
    do_reset();
    digit(4'd9); digit(4'd6); digit(4'd5); digit(4'd8); digit(4'd7);
    enter(2'd0);
    key(1'b1, 4'hF, 1'b0, 1'b0, 2'd0);
    enter(2'd0);
    key(1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    enter(2'd0);
    key(1'b1, 4'hF, 1'b0, 1'b0, 2'd0);
    enter(2'd3);

    // Clear, enter and a digit together: clear wins, nothing issues.
    digit(4'd5);
    key(1'b1, 4'd4, 1'b1, 1'b1, 2'd1);
    key(1'b0, 4'd0, 1'b0, 1'b0, 2'd1);
    enter(2'd1);

    // Display never asserts busy: WAIT ends on the timeout.
    ov_a = 100; ov_m = 1;
    enter(2'd2);

    // Reset in the middle of ISSUE.
    digit(4'd7);
    dl.key_enter = 1'b1;
    dl.mode_in   = 2'd2;
    it.digits    = mdigits();
    it.mode      = 2'd2;
    it.ovf       = movf;
    it.wait_len  = 0;
    sb.push_back(it);
    tick();
    dl.key_enter = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_set", 32'(dl.set), 32'd0);
    chk("abort_start", 32'(dl.start), 32'd0);
    chk("abort_digits", 32'(dl.digits), 32'hFFFF);
    chk("abort_busy", 32'(dl.busy), 32'd0);
    chk("abort_mode", 32'(dl.mode), 32'd0);
    rst = 1'b0;
    mbuf.delete();
    movf  = 1'b0;
    mpend = 1'b0;

    // Keys 1 and 10 with mode 3 (each also auto-issues when that build option is on).
    key(1'b0, 4'd0, 1'b0, 1'b0, 2'd3);
    digit(4'd1);
    key(1'b0, 4'd0, 1'b0, 1'b0, 2'd3);
    key(1'b1, 4'd10, 1'b0, 1'b0, 2'd3);
    key(1'b0, 4'd0, 1'b0, 1'b0, 2'd3);
    enter(2'd3);

    // Randomized key traffic.
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 99);
      mi = 2'($urandom_range(0, 3));
      if (r < 40)      key(1'b1, 4'($urandom_range(0, 14)), 1'b0, 1'b0, mi);
      else if (r < 55) key(1'b1, 4'hF, 1'b0, 1'b0, mi);
      else if (r < 62) key(1'b0, 4'd0, 1'b1, 1'b0, mi);
      else if (r < 75) key(1'b0, 4'd0, 1'b0, 1'b1, mi);
      else if (r < 82) key(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mi);
      else             key(1'b0, 4'd0, 1'b0, 1'b0, mi);
    end
    enter(2'd1);

    repeat (P + TMO + 4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
